// File: rtl/ad_capture_if.sv
// Sample stream from ad_capture to the averaging filter (ad_data_o/ad_vld_o -> ad_data_i/ad_vld_i).
interface ad_capture_if;
  logic [15:0] ad_data;
  logic        ad_vld;

  modport master (output ad_data, output ad_vld);
  modport slave  (input  ad_data, input  ad_vld);
endinterface

// File: rtl/ad_capture.sv
// Serial SAR ADC front end: periodic CNV pulse, 16-bit SCK readout, one-cycle sample strobe.
// Optional AD_CAPTURE_TESTPAT_EN: deliver an incrementing counter instead of ADC data.
module ad_capture #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CONV_CYC = 100
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         cfg_en,
  input  logic [15:0]  cfg_period,
  input  logic         ad_sdo_i,
  output logic         ad_cnv_o,
  output logic         ad_sck_o,
  output logic         busy_o,
  output logic         ovr_o,
  ad_capture_if.master ad_if
);

  localparam int unsigned DW   = 16;
  localparam int unsigned PCW  = 17;
  localparam int unsigned BW   = 4;
  localparam int unsigned TW   = (CONV_CYC > 1) ? $clog2(CONV_CYC) : 1;
  localparam int unsigned DVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PMIN = CONV_CYC + 32 * CLK_DIV + 2;
  localparam logic [PCW-1:0] PMIN_V = PCW'(PMIN);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_READ, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tmr, w_tmr_nxt;
  logic [DVW-1:0]  r_div, w_div_nxt;
  logic            r_half, w_half_nxt;
  logic [BW-1:0]   r_bit, w_bit_nxt;
  logic [DW-1:0]   r_sh, w_sh_nxt;
  logic            r_cnv, r_sck, r_busy, r_vld;
  logic [DW-1:0]   r_data;
  logic            w_cnv_nxt, w_sck_nxt, w_busy_nxt, w_vld_nxt;
  logic [DW-1:0]   w_data_nxt;
  logic [PCW-1:0]  r_pcnt, r_peff;
  logic            r_ovr;
  logic            w_trig, w_low;
`ifdef AD_CAPTURE_TESTPAT_EN
  logic [DW-1:0]   r_tp;
`endif

  assign w_low  = {1'b0, cfg_period} < PMIN_V;
  assign w_trig = cfg_en && (r_pcnt == '0) && (r_state == S_IDLE);

  // Period counter: a trigger samples cfg_period, so a change lands on the next period
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_peff <= PMIN_V;
      r_ovr  <= 1'b0;
    end else if (!cfg_en) begin
      r_pcnt <= '0;
      r_ovr  <= 1'b0;
    end else if (w_trig) begin
      r_peff <= w_low ? PMIN_V : {1'b0, cfg_period};
      r_ovr  <= r_ovr | w_low;
      r_pcnt <= PCW'(1);
    end else if (r_pcnt != '0) begin
      r_pcnt <= (r_pcnt == r_peff - PCW'(1)) ? '0 : r_pcnt + PCW'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_div   <= '0;
      r_half  <= 1'b0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_cnv   <= 1'b0;
      r_sck   <= 1'b0;
      r_busy  <= 1'b0;
      r_vld   <= 1'b0;
      r_data  <= '0;
`ifdef AD_CAPTURE_TESTPAT_EN
      r_tp    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_div   <= w_div_nxt;
      r_half  <= w_half_nxt;
      r_bit   <= w_bit_nxt;
      r_sh    <= w_sh_nxt;
      r_cnv   <= w_cnv_nxt;
      r_sck   <= w_sck_nxt;
      r_busy  <= w_busy_nxt;
      r_vld   <= w_vld_nxt;
      r_data  <= w_data_nxt;
`ifdef AD_CAPTURE_TESTPAT_EN
      if (r_state == S_DONE) r_tp <= r_tp + DW'(1);
`endif
    end
  end

  // Next state: CONV timer, then SCK low/high halves; SDO sampled at end of each high half
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_div_nxt   = r_div;
    w_half_nxt  = r_half;
    w_bit_nxt   = r_bit;
    w_sh_nxt    = r_sh;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_nxt = S_CONV;
          w_tmr_nxt   = '0;
        end
      end
      S_CONV: begin
        if (r_tmr == TW'(CONV_CYC - 1)) begin
          w_state_nxt = S_READ;
          w_div_nxt   = '0;
          w_half_nxt  = 1'b0;
          w_bit_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      S_READ: begin
        if (r_div == DVW'(CLK_DIV - 1)) begin
          w_div_nxt = '0;
          if (r_half) begin
            w_sh_nxt   = {r_sh[DW-2:0], ad_sdo_i};
            w_half_nxt = 1'b0;
            if (r_bit == BW'(15)) w_state_nxt = S_DONE;
            else                  w_bit_nxt   = r_bit + BW'(1);
          end else begin
            w_half_nxt = 1'b1;
          end
        end else begin
          w_div_nxt = r_div + DVW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the pins are registered yet state-aligned
  always_comb begin
    w_cnv_nxt  = 1'b0;
    w_sck_nxt  = 1'b0;
    w_busy_nxt = 1'b0;
    w_vld_nxt  = 1'b0;
    w_data_nxt = r_data;
    w_cnv_nxt  = (w_state_nxt == S_CONV);
    w_sck_nxt  = (w_state_nxt == S_READ) && w_half_nxt;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_vld_nxt  = (w_state_nxt == S_DONE);
    if (w_state_nxt == S_DONE) begin
`ifdef AD_CAPTURE_TESTPAT_EN
      w_data_nxt = r_tp;
`else
      w_data_nxt = w_sh_nxt;
`endif
    end
  end

  assign ad_cnv_o      = r_cnv;
  assign ad_sck_o      = r_sck;
  assign busy_o        = r_busy;
  assign ovr_o         = r_ovr;
  assign ad_if.ad_data = r_data;
  assign ad_if.ad_vld  = r_vld;

endmodule

// File: tb/tb_ad_capture.sv
// Directed bench for ad_capture with a behavioural serial ADC (MSB first, shifts on SCK fall).
module tb_ad_capture;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] cfg_period;
  logic        ad_sdo;
  logic        ad_cnv, ad_sck, busy, ovr;
  logic [15:0] adc_word;

  ad_capture_if u_if ();

  ad_capture #(.CLK_DIV(2), .CONV_CYC(100)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .cfg_period (cfg_period),
    .ad_sdo_i   (ad_sdo),
    .ad_cnv_o   (ad_cnv),
    .ad_sck_o   (ad_sck),
    .busy_o     (busy),
    .ovr_o      (ovr),
    .ad_if      (u_if)
  );

  always #5 clk_sys = ~clk_sys;

  // ADC model: bit index restarts on CNV rise, advances on every SCK fall
  int bidx = 0;
  always @(posedge ad_cnv or negedge ad_sck) begin
    if (ad_cnv) bidx = 0;
    else        bidx = bidx + 1;
  end
  assign ad_sdo = (bidx < 16) ? adc_word[15 - bidx] : 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pin monitor sampled on the falling edge
  int   cyc = 0;
  int   cnv_rise_cyc = 0, cnv_run = 0, cnv_len = 0, cnv_total = 0;
  int   sck_run = 0, vld_cyc = 0, vld_prev = 0, vld_total = 0, tp_exp = 0;
  logic p_cnv = 1'b0, p_sck = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (!rst_n) tp_exp = 0;
    if (ad_cnv && !p_cnv) begin
      cnv_rise_cyc = cyc;
      cnv_run      = 0;
      sck_run      = 0;
      cnv_total++;
    end
    if (ad_cnv) cnv_run++;
    if (!ad_cnv && p_cnv) cnv_len = cnv_run;
    if (ad_sck && !p_sck) sck_run++;
    if (u_if.ad_vld) begin
      vld_prev = vld_cyc;
      vld_cyc  = cyc;
      vld_total++;
      tp_exp++;
    end
    p_cnv = ad_cnv;
    p_sck = ad_sck;
  end

  function automatic logic [15:0] exp_data(input logic [15:0] w);
`ifdef AD_CAPTURE_TESTPAT_EN
    return 16'(tp_exp - 1);
`else
    return w;
`endif
  endfunction

  task automatic wait_vld(input string tag, input int max);
    int start;
    int n;
    start = vld_total;
    n = 0;
    while (vld_total == start && n < max) begin
      @(negedge clk_sys); #1;
      n++;
    end
    if (vld_total == start) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [15:0] words [3];
  int s, n, v0, rel;

  initial begin
    words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'h8001;
    rst_n = 1'b0; cfg_en = 1'b0; cfg_period = 16'd200; adc_word = 16'hA5C3;
    repeat (3) @(negedge clk_sys);
    #1;
    check("rst_cnv",  32'(ad_cnv), 32'd0);
    check("rst_sck",  32'(ad_sck), 32'd0);
    check("rst_data", 32'(u_if.ad_data), 32'd0);
    check("rst_vld",  32'(u_if.ad_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr",  32'(ovr), 32'd0);
    @(negedge clk_sys); rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    #1;

    // Default timing at period 200
    cfg_en = 1'b1;
    wait_vld("t1a", 400);
    check("t1_data",   32'(u_if.ad_data), 32'(exp_data(16'hA5C3)));
    check("t1_lat",    32'(vld_cyc - cnv_rise_cyc), 32'd164);
    check("t1_cnvlen", 32'(cnv_len), 32'd100);
    check("t1_sck",    32'(sck_run), 32'd16);
    check("t1_busy",   32'(busy), 32'd1);
    wait_vld("t1b", 400);
    check("t1_data2",  32'(u_if.ad_data), 32'(exp_data(16'hA5C3)));
    check("t1_period", 32'(vld_cyc - vld_prev), 32'd200);
    check("t1_ovr",    32'(ovr), 32'd0);
    @(negedge clk_sys); #1;
    check("t1_vld_1cyc", 32'(u_if.ad_vld), 32'd0);
    check("t1_hold",   32'(u_if.ad_data), 32'(exp_data(16'hA5C3)));
    check("t1_idle",   32'(busy), 32'd0);

    // Period below minimum clamps to 166 and flags overrun
    cfg_period = 16'd100;
    for (int i = 0; i < 3; i++) wait_vld("t2", 400);
    check("t2_period", 32'(vld_cyc - vld_prev), 32'd166);
    check("t2_ovr",    32'(ovr), 32'd1);
    cfg_en = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1;
    check("t2_ovr_clr", 32'(ovr), 32'd0);
    repeat (300) @(negedge clk_sys);
    #1;

    // Edge-case words
    cfg_period = 16'd200;
    for (int i = 0; i < 3; i++) begin
      adc_word = words[i];
      cfg_en   = 1'b1;
      wait_vld("t3", 400);
      check($sformatf("t3_word%0d", i), 32'(u_if.ad_data), 32'(exp_data(words[i])));
    end
    check("t3_ovr", 32'(ovr), 32'd0);

    // Disable 50 cycles into CONV: sample completes, no further CNV
    adc_word = 16'h3C5A;
    s = cnv_total; n = 0;
    while (cnv_total == s && n < 400) begin @(negedge clk_sys); #1; n++; end
    check("t4_cnv_seen", 32'(cnv_total - s), 32'd1);
    repeat (49) @(negedge clk_sys);
    #1;
    check("t4_cnv_mid", 32'(ad_cnv), 32'd1);
    cfg_en = 1'b0;
    wait_vld("t4", 400);
    check("t4_data", 32'(u_if.ad_data), 32'(exp_data(16'h3C5A)));
    check("t4_lat",  32'(vld_cyc - cnv_rise_cyc), 32'd164);
    s = cnv_total;
    repeat (400) @(negedge clk_sys);
    #1;
    check("t4_no_cnv", 32'(cnv_total - s), 32'd0);
    check("t4_busy",   32'(busy), 32'd0);

    // Reset during bit 7 of the readout
    adc_word = 16'h1234;
    s = cnv_total; n = 0;
    cfg_en = 1'b1;
    while (!(cnv_total != s && sck_run >= 8) && n < 400) begin @(negedge clk_sys); #1; n++; end
    check("t5_in_read", 32'(ad_sck), 32'd1);
    check("t5_bit7",    32'(sck_run), 32'd8);
    v0 = vld_total;
    rst_n = 1'b0;
    #1;
    check("t5_cnv",  32'(ad_cnv), 32'd0);
    check("t5_sck",  32'(ad_sck), 32'd0);
    check("t5_data", 32'(u_if.ad_data), 32'd0);
    check("t5_vld",  32'(u_if.ad_vld), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ovr",  32'(ovr), 32'd0);
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    rel = cyc;
    #1;
    check("t5_no_vld", 32'(vld_total - v0), 32'd0);
    wait_vld("t5", 400);
    check("t5_count",  32'(vld_total - v0), 32'd1);
    check("t5_fresh",  32'(vld_cyc - rel), 32'd165);
    check("t5_lat",    32'(vld_cyc - cnv_rise_cyc), 32'd164);
    check("t5_data2",  32'(u_if.ad_data), 32'(exp_data(16'h1234)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
